// File: rtl/vfiu_pkg.sv
// Shared vFIU route definitions and the sender authorisation rule used by
// both the receive filter and gateway_recv.
package vfiu_pkg;

  localparam int unsigned ROUTE_BITS  = 14;
  localparam int unsigned SENDER_LSB  = 6;
  localparam int unsigned SENDER_MSB  = 9;
  localparam int unsigned SENDER_BITS = SENDER_MSB - SENDER_LSB + 1;

  typedef logic [ROUTE_BITS-1:0]  route_t;
  typedef logic [SENDER_BITS-1:0] sender_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } filt_state_t;

  // Sender 0 on either side is a wildcard (host-open or external sender).
  function automatic logic route_sender_ok(input route_t ctrl, input route_t route);
    sender_t a;
    sender_t i;
    a = ctrl[SENDER_MSB:SENDER_LSB];
    i = route[SENDER_MSB:SENDER_LSB];
    return (i == a) || (a == '0) || (i == '0);
  endfunction

endpackage

// File: rtl/vfiu_skid_buf.sv
// Two-entry skid buffer: registered output slot plus one overflow entry,
// with a registered input ready so nothing upstream sees a comb path from out_ready.
module vfiu_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire;

  assign in_fire = in_valid_i & in_ready_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready_i) begin
      // Output slot frees up: refill from skid first to keep beat order.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/vfiu_recv_filter.sv
// vFIU receive-path sender filter: checks each packet's route on its first
// beat, forwards authorised packets and silently consumes the rest.
module vfiu_recv_filter
  import vfiu_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 512,
  parameter int unsigned ROUTE_BITS = vfiu_pkg::ROUTE_BITS,
  parameter int unsigned CNT_BITS   = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ROUTE_BITS-1:0]   route_ctrl,
  input  logic                    clear_cnt,
  input  logic [DATA_BITS-1:0]    s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]  s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [ROUTE_BITS-1:0]   s_axis_troute,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_BITS-1:0]    m_axis_tdata,
  output logic [DATA_BITS/8-1:0]  m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [ROUTE_BITS-1:0]   m_axis_troute,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [CNT_BITS-1:0]     pass_cnt,
  output logic [CNT_BITS-1:0]     drop_cnt,
  output logic                    route_err,
  output logic [SENDER_BITS-1:0]  err_sender
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned PAY_BITS  = DATA_BITS + KEEP_BITS + 1 + ROUTE_BITS;

  filt_state_t             state_q;
  logic [ROUTE_BITS-1:0]   route_q;
  logic [CNT_BITS-1:0]     pass_cnt_q, pass_cnt_d;
  logic [CNT_BITS-1:0]     drop_cnt_q, drop_cnt_d;
  logic                    route_err_q;
  logic [SENDER_BITS-1:0]  err_sender_q;

  logic                    buf_in_ready;
  logic                    buf_in_valid;
  logic [PAY_BITS-1:0]     buf_in_data;
  logic [PAY_BITS-1:0]     buf_out_data;
  logic                    first_beat;
  logic                    beat_acc;
  logic                    sender_ok;
  logic                    pass_inc;
  logic                    drop_inc;

  // Ready depends only on registered state, never on this cycle's ok decision.
  assign s_axis_tready = (state_q == DROP) | buf_in_ready;
  assign beat_acc      = s_axis_tvalid & s_axis_tready;
  assign first_beat    = (state_q == IDLE);
  assign sender_ok     = route_sender_ok(route_t'(route_ctrl), route_t'(s_axis_troute));
  assign pass_inc      = beat_acc & first_beat & sender_ok;
  assign drop_inc      = beat_acc & first_beat & ~sender_ok;
  assign buf_in_valid  = s_axis_tvalid & ((first_beat & sender_ok) | (state_q == PASS));
  assign buf_in_data   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                          first_beat ? s_axis_troute : route_q};

  vfiu_skid_buf #(
    .W (PAY_BITS)
  ) u_skid (
    .clk         (aclk),
    .rst         (areset),
    .in_data_i   (buf_in_data),
    .in_valid_i  (buf_in_valid),
    .in_ready_o  (buf_in_ready),
    .out_data_o  (buf_out_data),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_troute} = buf_out_data;

  // Packet-framing FSM; route is latched on the first beat for the whole packet.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat_acc) begin
            route_q <= s_axis_troute;
            if (!s_axis_tlast) state_q <= sender_ok ? PASS : DROP;
          end
        end
        PASS, DROP: begin
          if (beat_acc && s_axis_tlast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating counters; a clear wins over a same-cycle event.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_cnt) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (pass_inc && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_BITS'(1);
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pass_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      route_err_q  <= 1'b0;
      err_sender_q <= '0;
    end else begin
      pass_cnt_q  <= pass_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      route_err_q <= drop_inc;
      if (drop_inc) err_sender_q <= s_axis_troute[SENDER_MSB:SENDER_LSB];
    end
  end

  assign pass_cnt   = pass_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign route_err  = route_err_q;
  assign err_sender = err_sender_q;

endmodule

// File: tb/tb_vfiu_recv_filter.sv
// Randomised bench for vfiu_recv_filter: a packet-level model predicts the
// forwarded beat stream, counters and error reporting.
module tb_vfiu_recv_filter;

  localparam int unsigned DB = 64;
  localparam int unsigned KB = DB / 8;
  localparam int unsigned RB = 14;
  localparam int unsigned CB = 4;
  localparam int unsigned CMAX = (1 << CB) - 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [RB-1:0] route_ctrl;
  logic          clear_cnt;
  logic [DB-1:0] s_axis_tdata;
  logic [KB-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic [RB-1:0] s_axis_troute;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DB-1:0] m_axis_tdata;
  logic [KB-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [RB-1:0] m_axis_troute;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [CB-1:0] pass_cnt;
  logic [CB-1:0] drop_cnt;
  logic          route_err;
  logic [3:0]    err_sender;

  vfiu_recv_filter #(.DATA_BITS(DB), .ROUTE_BITS(RB), .CNT_BITS(CB)) dut (
    .aclk(aclk), .areset(areset), .route_ctrl(route_ctrl), .clear_cnt(clear_cnt),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_troute(s_axis_troute), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_troute(m_axis_troute), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .route_err(route_err), .err_sender(err_sender)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DB-1:0] d;
    logic [KB-1:0] k;
    logic          l;
    logic [RB-1:0] r;
  } beat_t;

  beat_t      exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_pass = 0;
  int         exp_drop = 0;
  int         exp_err_pulses = 0;
  int         err_seen = 0;
  logic [3:0] exp_err_sender = '0;
  bit         rand_ready = 0;

  // Sink ready: held high, or a 50% coin toss each cycle.
  always begin
    @(posedge aclk);
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: order/content scoreboard, AXI stability, error pulse count.
  logic          prev_stall = 0;
  logic [DB-1:0] prev_d;
  logic [KB-1:0] prev_k;
  logic          prev_l;
  logic [RB-1:0] prev_r;
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tkeep !== prev_k ||
            m_axis_tlast !== prev_l || m_axis_troute !== prev_r) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h r=%h, required v=1 d=%h r=%h",
                   m_axis_tvalid, m_axis_tdata, m_axis_troute, prev_d, prev_r);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got d=%h r=%h, required no output", m_axis_tdata, m_axis_troute);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tlast !== e.l ||
              m_axis_troute !== e.r) begin
            miscompares++;
            $display("FAIL out_beat: got d=%h k=%h l=%b r=%h, required d=%h k=%h l=%b r=%h",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_troute, e.d, e.k, e.l, e.r);
          end
        end
      end
      if (route_err === 1'b1) err_seen++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_k = m_axis_tkeep;
      prev_l = m_axis_tlast;
      prev_r = m_axis_troute;
    end
  end

  task automatic set_ctrl(input logic [3:0] snd);
    route_ctrl = RB'($urandom);
    route_ctrl[9:6] = snd;
  endtask

  // Offer one beat and wait for the handshake (returns 1 ns after the accepting edge).
  task automatic wait_accept();
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (s_axis_tready === 1'b1) begin
        @(posedge aclk);
        #1;
        return;
      end
      @(posedge aclk);
      #1;
    end
    vectors++;
    miscompares++;
    $display("FAIL accept_timeout: got tready=%b, required 1 within 200 cycles", s_axis_tready);
    $fatal(1, "input handshake never completed");
  endtask

  task automatic send_pkt(input int len, input logic [3:0] snd, input int mid_ctrl,
                          input bit term, input bit chk_lat);
    logic [RB-1:0] r;
    logic [3:0]    a;
    bit            ok;
    beat_t         b;
    r = RB'($urandom);
    r[9:6] = snd;
    ok = 1;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.k = KB'($urandom);
      b.l = term && (i == len - 1);
      b.r = r;
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_troute = (i == 0) ? r : RB'($urandom);
      s_axis_tvalid = 1'b1;
      a = route_ctrl[9:6];
      wait_accept();
      if (i == 0) begin
        ok = (snd == a) || (a == 4'd0) || (snd == 4'd0);
        if (ok) begin
          exp_pass = (exp_pass == CMAX) ? exp_pass : exp_pass + 1;
        end else begin
          exp_drop = (exp_drop == CMAX) ? exp_drop : exp_drop + 1;
          exp_err_pulses++;
          exp_err_sender = snd;
        end
        if (chk_lat) begin
          vectors++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== b.d || m_axis_troute !== r) begin
            miscompares++;
            $display("FAIL first_latency: got v=%b d=%h r=%h, required v=1 d=%h r=%h",
                     m_axis_tvalid, m_axis_tdata, m_axis_troute, b.d, r);
          end
        end
        if (mid_ctrl >= 0) route_ctrl[9:6] = 4'(mid_ctrl);
      end
      if (ok) exp_q.push_back(b);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int c;
    s_axis_tvalid = 1'b0;
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(posedge aclk);
      c++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic clear_counters();
    clear_cnt = 1'b1;
    @(posedge aclk);
    #1;
    clear_cnt = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    clear_cnt = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    s_axis_troute = '0;
    set_ctrl(4'd0);
    repeat (3) @(posedge aclk);
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got mv=%b sr=%b, required 0 0", m_axis_tvalid, s_axis_tready);
    end
    vectors++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0 || m_axis_troute !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got d=%h k=%h l=%b r=%h, required all 0",
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_troute);
    end
    vectors++;
    if (pass_cnt !== '0 || drop_cnt !== '0 || route_err !== 1'b0 || err_sender !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_status: got p=%0d d=%0d e=%b s=%0d, required 0 0 0 0",
               pass_cnt, drop_cnt, route_err, err_sender);
    end
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_pass();
    clear_counters();
    set_ctrl(4'd3);
    send_pkt(4, 4'd3, -1, 1, 1);
    drain();
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || drop_cnt !== CB'(exp_drop) || exp_pass != 1) begin
      miscompares++;
      $display("FAIL pass_counts: got p=%0d d=%0d, required p=%0d d=%0d", pass_cnt, drop_cnt, exp_pass, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    clear_counters();
    e0 = err_seen;
    set_ctrl(4'd3);
    send_pkt(3, 4'd5, -1, 1, 0);
    send_pkt(2, 4'd0, -1, 1, 0);
    drain();
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || drop_cnt !== CB'(exp_drop)) begin
      miscompares++;
      $display("FAIL b2b_counts: got p=%0d d=%0d, required p=%0d d=%0d", pass_cnt, drop_cnt, exp_pass, exp_drop);
    end
    vectors++;
    if (err_sender !== 4'd5 || err_seen - e0 != 1) begin
      miscompares++;
      $display("FAIL b2b_err: got sender=%0d pulses=%0d, required sender=5 pulses=1", err_sender, err_seen - e0);
    end
    send_pkt(2, 4'd3, -1, 1, 0);
    send_pkt(1, 4'd9, -1, 1, 0);
    send_pkt(2, 4'd3, -1, 1, 0);
    drain();
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || drop_cnt !== CB'(exp_drop) || err_sender !== exp_err_sender) begin
      miscompares++;
      $display("FAIL b2b_mixed: got p=%0d d=%0d s=%0d, required p=%0d d=%0d s=%0d",
               pass_cnt, drop_cnt, err_sender, exp_pass, exp_drop, exp_err_sender);
    end
  endtask

  task automatic test_wildcard();
    logic [3:0] snd [3];
    snd[0] = 4'd1; snd[1] = 4'd7; snd[2] = 4'd15;
    clear_counters();
    set_ctrl(4'd0);
    for (int i = 0; i < 3; i++) send_pkt(1, snd[i], -1, 1, 0);
    drain();
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || exp_pass != 3) begin
      miscompares++;
      $display("FAIL wildcard_pass: got p=%0d, required 3", pass_cnt);
    end
    clear_counters();
    set_ctrl(4'd2);
    for (int i = 0; i < 3; i++) send_pkt(1, snd[i], -1, 1, 0);
    drain();
    vectors++;
    if (drop_cnt !== CB'(exp_drop) || pass_cnt !== CB'(exp_pass) || exp_drop != 3) begin
      miscompares++;
      $display("FAIL wildcard_drop: got p=%0d d=%0d, required p=0 d=3", pass_cnt, drop_cnt);
    end
  endtask

  task automatic test_stall();
    clear_counters();
    set_ctrl(4'd3);
    rand_ready = 1;
    send_pkt(8, 4'd3, 9, 1, 0);
    send_pkt(3, 4'd3, -1, 1, 0);
    drain();
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || exp_pass != 1) begin
      miscompares++;
      $display("FAIL stall_counts: got p=%0d, required 1", pass_cnt);
    end
    rand_ready = 0;
  endtask

  task automatic test_random();
    clear_counters();
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) set_ctrl(4'($urandom_range(0, 3)));
      send_pkt($urandom_range(1, 6), 4'($urandom_range(0, 3)), -1, 1, 0);
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
    end
    drain();
    rand_ready = 0;
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || drop_cnt !== CB'(exp_drop) || err_sender !== exp_err_sender) begin
      miscompares++;
      $display("FAIL random_counts: got p=%0d d=%0d s=%0d, required p=%0d d=%0d s=%0d",
               pass_cnt, drop_cnt, err_sender, exp_pass, exp_drop, exp_err_sender);
    end
    vectors++;
    if (err_seen != exp_err_pulses) begin
      miscompares++;
      $display("FAIL err_pulses: got %0d, required %0d", err_seen, exp_err_pulses);
    end
  endtask

  task automatic test_saturation();
    clear_counters();
    set_ctrl(4'd2);
    for (int i = 0; i < 16; i++) send_pkt(1, 4'd5, -1, 1, 0);
    drain();
    vectors++;
    if (drop_cnt !== CB'(exp_drop) || exp_drop != CMAX) begin
      miscompares++;
      $display("FAIL drop_saturate: got d=%0d, required %0d", drop_cnt, CMAX);
    end
    clear_cnt = 1'b1;
    send_pkt(1, 4'd6, -1, 1, 0);
    clear_cnt = 1'b0;
    exp_drop = 0;
    exp_pass = 0;
    drain();
    vectors++;
    if (drop_cnt !== CB'(exp_drop) || err_sender !== 4'd6) begin
      miscompares++;
      $display("FAIL clear_priority: got d=%0d s=%0d, required d=0 s=6", drop_cnt, err_sender);
    end
  endtask

  task automatic test_reset_mid();
    clear_counters();
    set_ctrl(4'd3);
    send_pkt(2, 4'd3, -1, 0, 0);
    #1;
    areset = 1'b1;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || pass_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got mv=%b sr=%b p=%0d, required 0 0 0", m_axis_tvalid, s_axis_tready, pass_cnt);
    end
    exp_q.delete();
    exp_pass = 0;
    exp_drop = 0;
    exp_err_sender = '0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    send_pkt(3, 4'd9, -1, 1, 0);
    drain();
    vectors++;
    if (pass_cnt !== CB'(exp_pass) || drop_cnt !== CB'(exp_drop) || err_sender !== exp_err_sender ||
        exp_drop != 1) begin
      miscompares++;
      $display("FAIL post_reset_first: got p=%0d d=%0d s=%0d, required p=0 d=1 s=9",
               pass_cnt, drop_cnt, err_sender);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_back_to_back();
    test_wildcard();
    test_stall();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
